// File: rtl/spi_sclk_engine_if.sv
// Control/status bundle between the SPI register block and the SCLK engine.
interface spi_sclk_engine_if #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 6
);
    logic             i_enable;
    logic             i_start;
    logic             i_stop;
    logic             i_cpol;
    logic             i_cpha;
    logic [DIV_W-1:0] i_divider;
    logic [CNT_W-1:0] i_bit_cnt;

    logic             o_busy;
    logic             o_sclk;
    logic             o_lead_edge;
    logic             o_trail_edge;
    logic             o_sample;
    logic             o_shift;
    logic [CNT_W-1:0] o_bit_idx;
    logic             o_done;

    modport master (
        output i_enable, i_start, i_stop, i_cpol, i_cpha, i_divider, i_bit_cnt,
        input  o_busy, o_sclk, o_lead_edge, o_trail_edge, o_sample, o_shift, o_bit_idx, o_done
    );

    modport slave (
        input  i_enable, i_start, i_stop, i_cpol, i_cpha, i_divider, i_bit_cnt,
        output o_busy, o_sclk, o_lead_edge, o_trail_edge, o_sample, o_shift, o_bit_idx, o_done
    );
endinterface

// File: rtl/spi_sclk_engine.sv
// Single-edge SPI serial-clock generator with CPOL/CPHA support, bit counting,
// abort, and phase-aligned sample/shift strobes for the shift register.
module spi_sclk_engine #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    spi_sclk_engine_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_e;

    state_e           state_q;
    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] h1_q;
    logic [DIV_W-1:0] h2_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] bit_idx_q;
    logic             cpol_q;
    logic             cpha_q;
    logic             act_q;
    logic             busy_q;
    logic             sclk_q;
    logic             lead_q;
    logic             trail_q;
    logic             sample_q;
    logic             shift_q;
    logic             done_q;

    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] h1_d;
    logic [DIV_W-1:0] h2_d;
    logic             start_ok;
    logic             abort;
    logic             tick;
    logic             last_bit;

    // Effective divider is clamped to 2; the idle phase takes the extra cycle of an odd divider.
    always_comb begin
        div_d    = (bus.i_divider < DIV_W'(2)) ? DIV_W'(2) : bus.i_divider;
        h1_d     = div_d >> 1;
        h2_d     = div_d - h1_d;
        start_ok = bus.i_enable && bus.i_start && !bus.i_stop && (bus.i_bit_cnt != '0);
        abort    = bus.i_stop || !bus.i_enable;
        tick     = (rem_q == DIV_W'(1));
        last_bit = (bit_idx_q == (n_q - CNT_W'(1)));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            h1_q      <= '0;
            h2_q      <= '0;
            n_q       <= '0;
            bit_idx_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            act_q     <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
            sample_q  <= 1'b0;
            shift_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            lead_q   <= 1'b0;
            trail_q  <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    sclk_q    <= bus.i_cpol;
                    bit_idx_q <= '0;
                    busy_q    <= 1'b0;
                    act_q     <= 1'b0;
                    if (start_ok) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        h1_q    <= h1_d;
                        h2_q    <= h2_d;
                        rem_q   <= h2_d;
                        n_q     <= bus.i_bit_cnt;
                        cpol_q  <= bus.i_cpol;
                        cpha_q  <= bus.i_cpha;
                        // Mode 0/2 must present the first MOSI bit before the first leading edge.
                        shift_q <= !bus.i_cpha;
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        sclk_q    <= cpol_q;
                        act_q     <= 1'b0;
                        bit_idx_q <= '0;
                    end else if (tick) begin
                        if (!act_q) begin
                            act_q    <= 1'b1;
                            sclk_q   <= ~cpol_q;
                            lead_q   <= 1'b1;
                            rem_q    <= h1_q;
                            sample_q <= !cpha_q;
                            shift_q  <= cpha_q;
                        end else begin
                            act_q    <= 1'b0;
                            sclk_q   <= cpol_q;
                            trail_q  <= 1'b1;
                            rem_q    <= h2_q;
                            sample_q <= cpha_q;
                            shift_q  <= !cpha_q && !last_bit;
                            if (last_bit) begin
                                state_q <= ST_TAIL;
                            end else begin
                                bit_idx_q <= bit_idx_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        rem_q <= rem_q - DIV_W'(1);
                    end
                end

                ST_TAIL: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        sclk_q    <= cpol_q;
                        bit_idx_q <= '0;
                    end else if (tick) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        bit_idx_q <= '0;
                    end else begin
                        rem_q <= rem_q - DIV_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy       = busy_q;
    assign bus.o_sclk       = sclk_q;
    assign bus.o_lead_edge  = lead_q;
    assign bus.o_trail_edge = trail_q;
    assign bus.o_sample     = sample_q;
    assign bus.o_shift      = shift_q;
    assign bus.o_bit_idx    = bit_idx_q;
    assign bus.o_done       = done_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Self-checking bench for spi_sclk_engine: closed-form event timing pushed to a
// scoreboard at start time, compared against every observed strobe.
module tb_spi_sclk_engine;

    localparam int unsigned DIV_W   = 8;
    localparam int unsigned CNT_W   = 6;
    localparam int          OBS_MAX = 1024;
    localparam int          NOLIM   = 100000;

    // kind: 0 lead, 1 trail, 2 sample, 3 shift, 4 done
    typedef struct {
        int   kind;
        int   cyc;
        int   idx;
        logic sclk;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests_run = 0;
    int   fails = 0;

    ev_t  exp_q[$];
    ev_t  obs[OBS_MAX];
    int   obs_n = 0;
    int   obs_rd = 0;

    logic [4:0] pulses;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_sclk_engine_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    spi_sclk_engine #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign pulses = {bus.o_done, bus.o_shift, bus.o_sample, bus.o_trail_edge, bus.o_lead_edge};

    // Record every strobe with the edge count it followed.
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (pulses[k] && obs_n < OBS_MAX) begin
                obs[obs_n] = '{k, cyc, int'(bus.o_bit_idx), bus.o_sclk};
                obs_n = obs_n + 1;
            end
        end
    end

    function automatic void ev_push(input int c, input int kind, input int idx, input logic s, input int upto);
        if (c <= upto) exp_q.push_back('{kind, c, idx, s});
    endfunction

    function automatic void push_expect(input int t, input int div, input int n,
                                        input logic cpol, input logic cpha, input int upto);
        int d, h1, h2, lc, tc, ti;
        d  = (div < 2) ? 2 : div;
        h1 = d / 2;
        h2 = d - h1;
        if (!cpha) ev_push(t, 3, 0, cpol, upto);
        for (int k = 0; k < n; k++) begin
            lc = t + k * d + h2;
            tc = t + (k + 1) * d;
            ti = (k == n - 1) ? k : k + 1;
            ev_push(lc, 0, k, ~cpol, upto);
            ev_push(lc, cpha ? 3 : 2, k, ~cpol, upto);
            ev_push(tc, 1, ti, cpol, upto);
            if (cpha) ev_push(tc, 2, ti, cpol, upto);
            else if (k < n - 1) ev_push(tc, 3, ti, cpol, upto);
        end
        ev_push(t + n * d + h2, 4, 0, cpol, upto);
    endfunction

    // Call at a negedge; returns at the negedge following acceptance edge t.
    task automatic start_xfer(input int div, input int n, input logic cpol, input logic cpha,
                              input int upto_rel, output int t);
        bus.i_divider = DIV_W'(div);
        bus.i_bit_cnt = CNT_W'(n);
        bus.i_cpol    = cpol;
        bus.i_cpha    = cpha;
        bus.i_enable  = 1'b1;
        bus.i_stop    = 1'b0;
        bus.i_start   = 1'b1;
        t = cyc + 1;
        push_expect(t, div, n, cpol, cpha, t + upto_rel);
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_enable = 1'b0; bus.i_start = 1'b0; bus.i_stop = 1'b0;
        bus.i_cpol = 1'b0; bus.i_cpha = 1'b0; bus.i_divider = '0; bus.i_bit_cnt = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.o_busy, bus.o_sclk, pulses, bus.o_bit_idx} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got busy=%b sclk=%b pulses=%b idx=%0d, required all 0",
                     bus.o_busy, bus.o_sclk, pulses, bus.o_bit_idx);
        end
        rst = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_cpol = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.o_sclk !== 1'b1 || bus.o_busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_cpol1 got sclk=%b busy=%b, required sclk=1 busy=0", bus.o_sclk, bus.o_busy);
        end
        bus.i_cpol = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.o_sclk !== 1'b0) begin
            fails++;
            $display("FAIL idle_cpol0 got sclk=%b, required 0", bus.o_sclk);
        end
        tests_run++;
        if (obs_n != 0) begin
            fails++;
            $display("FAIL reset_no_strobes got %0d strobes, required 0", obs_n);
        end
        obs_rd = obs_n;
    endtask

    task automatic test_mode0();
        int t; logic got; ev_t e, o;
        start_xfer(4, 2, 1'b0, 1'b0, NOLIM, t);
        tests_run++;
        if (bus.o_busy !== 1'b1) begin
            fails++; $display("FAIL mode0_busy got %b, required 1", bus.o_busy);
        end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = bus.o_done; end
        tests_run++;
        if (!got || cyc != t + 10 || bus.o_busy !== 1'b0) begin
            fails++;
            $display("FAIL mode0_done got seen=%b cyc=%0d busy=%b, required cyc=%0d busy=0", got, cyc, bus.o_busy, t + 10);
        end
        repeat (2) @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_rd >= obs_n) begin
                fails++; $display("FAIL mode0_sb got nothing, required kind=%0d cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o.kind !== e.kind || o.cyc !== e.cyc || o.idx !== e.idx || o.sclk !== e.sclk) begin
                    fails++;
                    $display("FAIL mode0_sb got kind=%0d cyc=%0d idx=%0d sclk=%b, required kind=%0d cyc=%0d idx=%0d sclk=%b",
                             o.kind, o.cyc, o.idx, o.sclk, e.kind, e.cyc, e.idx, e.sclk);
                end
            end
        end
        tests_run++;
        if (obs_rd != obs_n) begin fails++; $display("FAIL mode0_extra got %0d extra strobes, required 0", obs_n - obs_rd); end
        obs_rd = obs_n;
    endtask

    task automatic test_mode3();
        int t; logic got; ev_t e, o;
        @(negedge clk);
        start_xfer(5, 3, 1'b1, 1'b1, NOLIM, t);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = bus.o_done; end
        tests_run++;
        if (!got || cyc != t + 18) begin
            fails++; $display("FAIL mode3_done got seen=%b cyc=%0d, required cyc=%0d", got, cyc, t + 18);
        end
        tests_run++;
        if (bus.o_sclk !== 1'b1) begin
            fails++; $display("FAIL mode3_idle_level got sclk=%b, required 1", bus.o_sclk);
        end
        repeat (2) @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_rd >= obs_n) begin
                fails++; $display("FAIL mode3_sb got nothing, required kind=%0d cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o.kind !== e.kind || o.cyc !== e.cyc || o.idx !== e.idx || o.sclk !== e.sclk) begin
                    fails++;
                    $display("FAIL mode3_sb got kind=%0d cyc=%0d idx=%0d sclk=%b, required kind=%0d cyc=%0d idx=%0d sclk=%b",
                             o.kind, o.cyc, o.idx, o.sclk, e.kind, e.cyc, e.idx, e.sclk);
                end
            end
        end
        tests_run++;
        if (obs_rd != obs_n) begin fails++; $display("FAIL mode3_extra got %0d extra strobes, required 0", obs_n - obs_rd); end
        obs_rd = obs_n;
    endtask

    task automatic test_min_divider();
        int t; logic got; ev_t e, o;
        for (int dv = 0; dv < 2; dv++) begin
            @(negedge clk);
            start_xfer(dv, 1, 1'b0, 1'b0, NOLIM, t);
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = bus.o_done; end
            tests_run++;
            if (!got || cyc != t + 3) begin
                fails++; $display("FAIL mindiv%0d_done got seen=%b cyc=%0d, required cyc=%0d", dv, got, cyc, t + 3);
            end
        end
        @(negedge clk);
        bus.i_divider = DIV_W'(4);
        bus.i_bit_cnt = '0;
        bus.i_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.o_busy !== 1'b0) begin
                fails++; $display("FAIL zero_bits_busy got %b, required 0", bus.o_busy);
            end
        end
        bus.i_start = 1'b0;
        repeat (2) @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_rd >= obs_n) begin
                fails++; $display("FAIL mindiv_sb got nothing, required kind=%0d cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o.kind !== e.kind || o.cyc !== e.cyc || o.idx !== e.idx || o.sclk !== e.sclk) begin
                    fails++;
                    $display("FAIL mindiv_sb got kind=%0d cyc=%0d idx=%0d sclk=%b, required kind=%0d cyc=%0d idx=%0d sclk=%b",
                             o.kind, o.cyc, o.idx, o.sclk, e.kind, e.cyc, e.idx, e.sclk);
                end
            end
        end
        tests_run++;
        if (obs_rd != obs_n) begin fails++; $display("FAIL mindiv_extra got %0d extra strobes, required 0", obs_n - obs_rd); end
        obs_rd = obs_n;
    endtask

    task automatic test_abort();
        int t; ev_t e, o;
        @(negedge clk);
        start_xfer(6, 8, 1'b0, 1'b0, 20, t);
        for (int i = 0; i < 100 && cyc < t + 20; i++) @(negedge clk);
        bus.i_stop = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.o_busy, bus.o_sclk, bus.o_done} !== 3'b000) begin
            fails++; $display("FAIL stop_abort got busy/sclk/done=%b%b%b, required 000", bus.o_busy, bus.o_sclk, bus.o_done);
        end
        bus.i_stop = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.o_busy !== 1'b0) begin
            fails++; $display("FAIL stop_stays_idle got busy=%b, required 0", bus.o_busy);
        end
        start_xfer(6, 8, 1'b1, 1'b1, 14, t);
        for (int i = 0; i < 100 && cyc < t + 14; i++) @(negedge clk);
        bus.i_enable = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.o_busy, bus.o_sclk, bus.o_done} !== 3'b010) begin
            fails++; $display("FAIL enable_abort got busy/sclk/done=%b%b%b, required 010", bus.o_busy, bus.o_sclk, bus.o_done);
        end
        bus.i_enable = 1'b1;
        bus.i_cpol = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_bit_cnt = CNT_W'(2);
        bus.i_start = 1'b1;
        bus.i_stop = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.o_busy !== 1'b0) begin
            fails++; $display("FAIL start_stop_idle got busy=%b, required 0", bus.o_busy);
        end
        bus.i_start = 1'b0;
        bus.i_stop = 1'b0;
        repeat (8) @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_rd >= obs_n) begin
                fails++; $display("FAIL abort_sb got nothing, required kind=%0d cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o.kind !== e.kind || o.cyc !== e.cyc || o.idx !== e.idx || o.sclk !== e.sclk) begin
                    fails++;
                    $display("FAIL abort_sb got kind=%0d cyc=%0d idx=%0d sclk=%b, required kind=%0d cyc=%0d idx=%0d sclk=%b",
                             o.kind, o.cyc, o.idx, o.sclk, e.kind, e.cyc, e.idx, e.sclk);
                end
            end
        end
        tests_run++;
        if (obs_rd != obs_n) begin fails++; $display("FAIL abort_extra got %0d extra strobes, required 0", obs_n - obs_rd); end
        obs_rd = obs_n;
    endtask

    task automatic test_back_to_back();
        int t1, t2; logic got; ev_t e, o;
        @(negedge clk);
        start_xfer(4, 3, 1'b0, 1'b1, NOLIM, t1);
        // Scramble every control input and re-request while busy.
        bus.i_divider = DIV_W'(9);
        bus.i_cpol    = 1'b1;
        bus.i_cpha    = 1'b0;
        bus.i_bit_cnt = CNT_W'(1);
        bus.i_start   = 1'b1;
        @(negedge clk);
        bus.i_start   = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = bus.o_done; end
        tests_run++;
        if (!got || cyc != t1 + 14) begin
            fails++; $display("FAIL b2b_first_done got seen=%b cyc=%0d, required cyc=%0d", got, cyc, t1 + 14);
        end
        start_xfer(4, 3, 1'b0, 1'b1, NOLIM, t2);
        tests_run++;
        if (bus.o_busy !== 1'b1) begin
            fails++; $display("FAIL b2b_accept got busy=%b, required 1", bus.o_busy);
        end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = bus.o_done; end
        tests_run++;
        if (!got || cyc != t2 + 14) begin
            fails++; $display("FAIL b2b_second_done got seen=%b cyc=%0d, required cyc=%0d", got, cyc, t2 + 14);
        end
        repeat (2) @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_rd >= obs_n) begin
                fails++; $display("FAIL b2b_sb got nothing, required kind=%0d cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o.kind !== e.kind || o.cyc !== e.cyc || o.idx !== e.idx || o.sclk !== e.sclk) begin
                    fails++;
                    $display("FAIL b2b_sb got kind=%0d cyc=%0d idx=%0d sclk=%b, required kind=%0d cyc=%0d idx=%0d sclk=%b",
                             o.kind, o.cyc, o.idx, o.sclk, e.kind, e.cyc, e.idx, e.sclk);
                end
            end
        end
        tests_run++;
        if (obs_rd != obs_n) begin fails++; $display("FAIL b2b_extra got %0d extra strobes, required 0", obs_n - obs_rd); end
        obs_rd = obs_n;
    endtask

    task automatic test_async_reset();
        int t; logic got; ev_t e, o;
        @(negedge clk);
        start_xfer(6, 4, 1'b1, 1'b0, 8, t);
        for (int i = 0; i < 100 && cyc < t + 8; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.o_busy, bus.o_sclk, pulses, bus.o_bit_idx} !== '0) begin
            fails++;
            $display("FAIL async_reset got busy=%b sclk=%b pulses=%b idx=%0d, required all 0",
                     bus.o_busy, bus.o_sclk, pulses, bus.o_bit_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.i_cpol = 1'b0;
        @(negedge clk);
        start_xfer(3, 2, 1'b0, 1'b0, NOLIM, t);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); got = bus.o_done; end
        tests_run++;
        if (!got || cyc != t + 8) begin
            fails++; $display("FAIL post_reset_done got seen=%b cyc=%0d, required cyc=%0d", got, cyc, t + 8);
        end
        repeat (2) @(posedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_rd >= obs_n) begin
                fails++; $display("FAIL rst_sb got nothing, required kind=%0d cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o.kind !== e.kind || o.cyc !== e.cyc || o.idx !== e.idx || o.sclk !== e.sclk) begin
                    fails++;
                    $display("FAIL rst_sb got kind=%0d cyc=%0d idx=%0d sclk=%b, required kind=%0d cyc=%0d idx=%0d sclk=%b",
                             o.kind, o.cyc, o.idx, o.sclk, e.kind, e.cyc, e.idx, e.sclk);
                end
            end
        end
        tests_run++;
        if (obs_rd != obs_n) begin fails++; $display("FAIL rst_extra got %0d extra strobes, required 0", obs_n - obs_rd); end
        obs_rd = obs_n;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_min_divider();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
- Parametrised next-generation SPI serial-clock generator for the universal SPI master.
- Runs entirely on a single system clock edge: no inverted-clock domain, odd and even dividers share one path.
- Adds CPOL/CPHA mode support, a programmable bit count, a start/done handshake, abort, and phase-correct sample/shift strobes for the shift register.
- Sits between the SPI control registers and the shift register / chip-select logic.

Parameters:
DIV_W, 8, width of the divider input.
CNT_W, 6, width of the bit-count input and bit index.

Ports:
i_clk  in  1  system clock; all logic on rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_enable  in  1  block enable; low while busy aborts the transfer.
i_start  in  1  transfer request pulse/level, sampled only in IDLE.
i_stop  in  1  abort request.
i_cpol  in  1  idle level of SCLK.
i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
i_divider  in  DIV_W  SCLK period in i_clk cycles.
i_bit_cnt  in  CNT_W  bits per transfer, N.
o_busy  out  1  transfer in progress.
o_sclk  out  1  registered serial clock.
o_lead_edge  out  1  1-cycle pulse, coincident with SCLK leaving its idle level.
o_trail_edge  out  1  1-cycle pulse, coincident with SCLK returning to its idle level.
o_sample  out  1  1-cycle pulse: capture MISO.
o_shift  out  1  1-cycle pulse: drive next MOSI bit.
o_bit_idx  out  CNT_W  index of the bit in progress.
o_done  out  1  1-cycle pulse, normal completion.

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_sclk=0; o_busy, all pulses, and o_done = 0; o_bit_idx=0; counters cleared.

Start acceptance and latching:
- Start is accepted at edge T when state=IDLE, i_enable=1, i_start=1, i_stop=0, and i_bit_cnt!=0.
- Otherwise start is ignored. If i_start and i_stop coincide, stop wins.
- At acceptance, latch D = max(i_divider, 2), N = i_bit_cnt, cpol, and cpha.
- Input changes during the transfer are ignored.

Phase arithmetic:
- H1 = floor(D/2), H2 = D − H1. SCLK holds idle level for H2 cycles and active level for H1 cycles.
- Odd D: the active phase is one cycle shorter.
- Half-period counter is DIV_W bits wide; no overflow for any D ≤ 2^DIV_W − 1.

States:
- IDLE: o_sclk = i_cpol, registered with 1-cycle latency.
- RUN: transfer in progress.
  - Leading edge for bit k at T + k·D + H2; trailing edge at T + (k+1)·D, for k = 0..N−1.
  - o_sclk and the edge pulses assert on the same edge.
- TAIL: SCLK idle for H2 cycles after the last trailing edge.
  - At T + N·D + H2: o_done=1 for one cycle, o_busy→0, state→IDLE.
- o_busy=1 from edge T through the done edge exclusive.

Strobes:
- cpha=0:
  - o_sample on every leading edge.
  - o_shift at edge T (first-bit setup) and on trailing edges of bits 0..N−2.
- cpha=1:
  - o_shift on every leading edge.
  - o_sample on every trailing edge.
- Exactly N sample pulses and N shift pulses per completed transfer.

Bit index:
- o_bit_idx=0 at T; increments on each trailing edge except the last; holds N−1 through TAIL; returns to 0 in IDLE.

Abort:
- i_stop=1 or i_enable=0 while busy takes effect at the next edge: state→IDLE, o_sclk→cpol, o_busy→0, no o_done, no further strobes.
- A strobe due in the abort cycle is suppressed.

Back-to-back:
- A start may be accepted on the first cycle of IDLE after done. Minimum gap is one cycle with o_busy=0.

Reset mid-transfer:
- Immediate return to reset values; no o_done.

Test Plan:
1. D=4, N=2, cpol=0, cpha=0, start accepted at T → o_sclk rises T+2, T+6 and falls T+4, T+8. o_shift at T, T+4. o_sample at T+2, T+6. o_done at T+10.
2. D=5, N=3, cpol=1, cpha=1 → o_sclk low (active) for 2 cycles from T+3, T+8, T+13. o_shift on the falls, o_sample on the rises at T+5, T+10, T+15. o_bit_idx = 0, 1, 2. o_done at T+18.
3. i_divider=0 and 1, N=1 → behaves as D=2: lead at T+1, trail at T+2, o_done at T+3. i_bit_cnt=0 → start ignored, o_busy stays 0.
4. D=6, N=8: i_stop asserted at T+20 → edge T+21: o_busy=0, o_sclk=cpol, no o_done. Separately, i_enable dropped mid-transfer → same result. Start+stop together in IDLE → not accepted.
5. Change i_divider, i_cpol, i_bit_cnt mid-transfer → timing unchanged. New start issued while busy → ignored. Start on the cycle after o_done → accepted, second transfer timing identical.
6. Assert i_rst asynchronously mid-RUN, off-edge → all outputs zero immediately. After release, a start is accepted normally.
